// File: rtl/instr_fetch_pkg.sv
// Shared fetch-path types: address/instruction widths, reset vector, NOP encoding
// and the fetch FSM state encoding.
package instr_fetch_pkg;

   localparam int unsigned INSTR_ADDR_W = 32;
   localparam int unsigned INSTR_W      = 32;

   typedef logic [INSTR_ADDR_W-1:0] instruction_addr_path_t;
   typedef logic [INSTR_W-1:0]      instruction_path_t;

   localparam instruction_addr_path_t RESET_VECTOR = 32'h0000_0000;
   localparam instruction_path_t      NOP_INSTR    = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_REQ  = 2'd1,
      IF_WAIT = 2'd2
   } if_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem request, IF/ID output register with
// valid/ready toward decode, PC write-enable. Optional misaligned-fetch trap: FETCH_ALIGN_CHECK_EN.
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  instruction_addr_path_t pc_in,
   output logic                   pc_wr_en,
   input  logic                   redirect,
   output logic                   imem_req,
   output instruction_addr_path_t imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  instruction_path_t      imem_rdata,
   output logic                   id_valid,
   input  logic                   id_ready,
   output instruction_path_t      id_instr,
   output instruction_addr_path_t id_pc,
   output logic                   id_fault,
   output if_state_e              dbg_state
);

   // Decode handshake: a transfer completes in any cycle where id_valid && id_ready.
   // id_valid holds, with id_instr/id_pc stable, until that transfer or a redirect.

   if_state_e              state_q, state_d;
   instruction_addr_path_t pend_pc_q, pend_pc_d;
   logic                   discard_q, discard_d;
   logic                   id_valid_q, id_valid_d;
   instruction_path_t      id_instr_q, id_instr_d;
   instruction_addr_path_t id_pc_q, id_pc_d;
   logic                   id_fault_q, id_fault_d;

   logic out_free;
   logic misalign;
   logic fault_take;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misalign = (pc_in[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Requests go out only when the output register will be free on response.
   assign out_free  = !id_valid_q || id_ready;
   assign imem_addr = pc_in;

   always_comb begin
      state_d    = state_q;
      pend_pc_d  = pend_pc_q;
      discard_d  = discard_q;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_fault_d = id_fault_q;
      imem_req   = 1'b0;
      fault_take = 1'b0;

      if (id_valid_q && id_ready) begin
         id_valid_d = 1'b0;
         id_fault_d = 1'b0;
      end

      case (state_q)
         IF_IDLE: state_d = IF_REQ;
         IF_REQ: begin
            if (out_free && !redirect) begin
               if (misalign) begin
                  fault_take = 1'b1;
                  id_valid_d = 1'b1;
                  id_fault_d = 1'b1;
                  id_instr_d = NOP_INSTR;
                  id_pc_d    = pc_in;
               end else begin
                  imem_req = 1'b1;
                  if (imem_gnt) begin
                     pend_pc_d = pc_in;
                     discard_d = 1'b0;
                     state_d   = IF_WAIT;
                  end
               end
            end
         end
         IF_WAIT: begin
            if (imem_rvalid) begin
               state_d = IF_REQ;
               // A response arriving alongside a redirect belongs to the old stream.
               if (!discard_q && !redirect) begin
                  id_valid_d = 1'b1;
                  id_fault_d = 1'b0;
                  id_instr_d = imem_rdata;
                  id_pc_d    = pend_pc_q;
               end
            end
         end
         default: state_d = IF_IDLE;
      endcase

      // Redirect suppresses the request, so a same-cycle grant cannot occur;
      // only an in-flight WAIT response has to be marked for discard.
      if (redirect) begin
         id_valid_d = 1'b0;
         id_fault_d = 1'b0;
         if (state_q == IF_WAIT) discard_d = 1'b1;
      end
   end

   assign pc_wr_en = (imem_req && imem_gnt) || redirect || fault_take;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IF_IDLE;
         pend_pc_q  <= RESET_VECTOR;
         discard_q  <= 1'b0;
         id_valid_q <= 1'b0;
         id_instr_q <= NOP_INSTR;
         id_pc_q    <= RESET_VECTOR;
         id_fault_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_pc_q  <= pend_pc_d;
         discard_q  <= discard_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_fault_q <= id_fault_d;
      end
   end

   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign id_fault  = id_fault_q;
   assign dbg_state = state_q;

endmodule
